// File: rtl/value_cond_waiter.sv
// value_cond_waiter: steps through a programmed list of level-sensitive
// conditions on the `value` stream, one stage per cycle at most, and
// reports per-stage hits and a final done pulse.
// Optional build macro: VALUE_COND_WAITER_TIMEOUT_EN adds a per-stage
// timeout counter and drives `timeout`; without it `timeout` is tied 0.
module value_cond_waiter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  value,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_STAGES)-1:0]     cfg_idx,
  input  logic [2:0]                        cfg_op,
  input  logic [WIDTH-1:0]                  cfg_lo,
  input  logic [WIDTH-1:0]                  cfg_hi,
  input  logic [$clog2(NUM_STAGES+1)-1:0]   n_stages,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic [$clog2(NUM_STAGES)-1:0]     stage,
  output logic                              stage_hit,
  output logic                              done,
  output logic                              timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_STAGES);
  localparam int unsigned CNT_W = $clog2(NUM_STAGES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [2:0] OP_EQ    = 3'd0;
  localparam logic [2:0] OP_LT    = 3'd1;
  localparam logic [2:0] OP_GT    = 3'd2;
  localparam logic [2:0] OP_NE    = 3'd3;
  localparam logic [2:0] OP_RANGE = 3'd4;

  // Elaboration-time sanity check on the configuration.
  if (NUM_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("value_cond_waiter: NUM_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [0:0]       state;
  logic [IDX_W-1:0] last;

  logic [2:0]       tab_op [NUM_STAGES];
  logic [WIDTH-1:0] tab_lo [NUM_STAGES];
  logic [WIDTH-1:0] tab_hi [NUM_STAGES];

  logic [2:0]       cur_op;
  logic [WIDTH-1:0] cur_lo;
  logic [WIDTH-1:0] cur_hi;
  logic             match;
  logic             expire;
  logic [CNT_W-1:0] n_clamp;
  logic [IDX_W-1:0] last_in;

  assign busy = (state == S_WAIT);

  // Condition table: cleared on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        tab_op[i] <= OP_EQ;
        tab_lo[i] <= '0;
        tab_hi[i] <= '0;
      end
    end else if (cfg_we && (state == S_IDLE) && (32'(cfg_idx) < NUM_STAGES)) begin
      tab_op[cfg_idx] <= cfg_op;
      tab_lo[cfg_idx] <= cfg_lo;
      tab_hi[cfg_idx] <= cfg_hi;
    end
  end

  // Evaluate the current stage's condition against the live value.
  always_comb begin
    cur_op = tab_op[stage];
    cur_lo = tab_lo[stage];
    cur_hi = tab_hi[stage];
    match  = 1'b0;
    case (cur_op)
      OP_EQ:    match = (value == cur_lo);
      OP_LT:    match = (value <  cur_lo);
      OP_GT:    match = (value >  cur_lo);
      OP_NE:    match = (value != cur_lo);
      // Strict on both sides, so hi <= lo+1 can never match.
      OP_RANGE: match = (value > cur_lo) && (value < cur_hi);
      default:  match = 1'b0;
    endcase
  end

  // Clamp the requested stage count and derive the last stage index.
  always_comb begin
    n_clamp = n_stages;
    if (32'(n_stages) > NUM_STAGES) begin
      n_clamp = CNT_W'(NUM_STAGES);
    end
    last_in = IDX_W'(n_clamp - 1'b1);
  end

`ifdef VALUE_COND_WAITER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign expire = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Per-stage no-match counter; cleared on stage entry, match, abort or expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == S_IDLE) begin
        to_cnt <= '0;
      end else if (abort || match) begin
        to_cnt <= '0;
      end else if (expire) begin
        to_cnt  <= '0;
        timeout <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Sequencer: accept start in idle, advance one stage per matching cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stage     <= '0;
      last      <= '0;
      stage_hit <= 1'b0;
      done      <= 1'b0;
    end else begin
      stage_hit <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (n_stages == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_WAIT;
              stage <= '0;
              last  <= last_in;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            stage <= '0;
          end else if (match) begin
            stage_hit <= 1'b1;
            if (stage == last) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              stage <= stage + 1'b1;
            end
          end else if (expire) begin
            // Timeout leaves stage pointing at the stage that expired.
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_value_cond_waiter.sv
// Bench for value_cond_waiter: directed vector table, long-wait sequence,
// then randomized traffic checked against a behavioural model.
module tb_value_cond_waiter;

  localparam int W  = 32;
  localparam int NS = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst, cfg_we, start, abort;
  logic [W-1:0] value, cfg_lo, cfg_hi;
  logic [1:0]   cfg_idx;
  logic [2:0]   cfg_op, n_stages;
  logic         busy, stage_hit, done, timeout;
  logic [1:0]   stage;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  value_cond_waiter #(.WIDTH(W), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .value(value), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_op(cfg_op), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .n_stages(n_stages),
    .start(start), .abort(abort), .busy(busy), .stage(stage),
    .stage_hit(stage_hit), .done(done), .timeout(timeout)
  );

  // ---------------- behavioural model ----------------
  int           m_op [NS];
  logic [W-1:0] m_lo [NS];
  logic [W-1:0] m_hi [NS];
  bit           m_active;
  int           m_stage, m_len, m_cnt;
  bit           e_hit, e_done, e_to;

  function automatic bit cond(input int op, input logic [W-1:0] lo, hi, v);
    case (op)
      0: return v == lo;
      1: return v < lo;
      2: return v > lo;
      3: return v != lo;
      4: return (v > lo) && (v < hi);
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    e_hit = 0; e_done = 0; e_to = 0;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin m_op[i] = 0; m_lo[i] = '0; m_hi[i] = '0; end
      m_active = 0; m_stage = 0; m_cnt = 0;
    end else if (!m_active) begin
      if (cfg_we) begin
        m_op[cfg_idx] = int'(cfg_op); m_lo[cfg_idx] = cfg_lo; m_hi[cfg_idx] = cfg_hi;
      end
      if (start) begin
        if (n_stages == 0) e_done = 1;
        else begin
          m_active = 1; m_stage = 0; m_cnt = 0;
          m_len = (int'(n_stages) > NS) ? NS : int'(n_stages);
        end
      end
    end else if (abort) begin
      m_active = 0; m_stage = 0;
    end else if (cond(m_op[m_stage], m_lo[m_stage], m_hi[m_stage], value)) begin
      e_hit = 1; m_cnt = 0;
      if (m_stage == m_len - 1) begin e_done = 1; m_active = 0; end
      else m_stage++;
    end else begin
`ifdef VALUE_COND_WAITER_TIMEOUT_EN
      if (m_cnt + 1 == TO) begin e_to = 1; m_active = 0; m_cnt = 0; end
      else m_cnt++;
`endif
    end
  endtask

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {busy,stage,hit,done,timeout}=%b required %b", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {busy, stage, stage_hit, done, timeout};
  endfunction

  task automatic set_in(input bit r, s, a, input int n, input bit we, input int idx,
                        input int op, input logic [W-1:0] lo, hi, v);
    rst = r; start = s; abort = a; n_stages = 3'(n); cfg_we = we;
    cfg_idx = 2'(idx); cfg_op = 3'(op); cfg_lo = lo; cfg_hi = hi; value = v;
  endtask

  // One clock: model advance, DUT edge, sample 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_model(input string nm);
    tick();
    chk(nm, outs(), {m_active, 2'(m_stage), e_hit, e_done, e_to});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r, s, a; int n; bit we; int idx, op; logic [W-1:0] lo, hi, v;
    bit busy; int st; bit hit, dn;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t row(input bit r, s, a, input int n, input bit we,
                               input int idx, op, input logic [W-1:0] lo, hi, v,
                               input bit b, input int st, input bit h, d);
    vec_t x;
    x.r = r; x.s = s; x.a = a; x.n = n; x.we = we; x.idx = idx; x.op = op;
    x.lo = lo; x.hi = hi; x.v = v; x.busy = b; x.st = st; x.hit = h; x.dn = d;
    return x;
  endfunction

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //             r s a n we i op lo hi  v   busy st hit done
    vt.push_back(row(1,0,0,0,0,0,0, 0, 0, 0,  0,0,0,0)); // reset
    vt.push_back(row(0,0,0,0,1,0,0, 2, 0, 0,  0,0,0,0)); // EQ 2
    vt.push_back(row(0,0,0,0,1,1,1, 2, 0, 0,  0,0,0,0)); // LT 2
    vt.push_back(row(0,0,0,0,1,2,0, 0, 0, 0,  0,0,0,0)); // EQ 0
    vt.push_back(row(0,0,0,0,1,3,4, 1, 3, 0,  0,0,0,0)); // RANGE 1..3
    vt.push_back(row(0,1,0,4,0,0,0, 0, 0, 0,  1,0,0,0)); // start n=4
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 0,  1,0,0,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 1,  1,0,0,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 1,  1,0,0,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 2,  1,1,1,0)); // hit 0
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 0,  1,2,1,0)); // hit 1
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 0,  1,3,1,0)); // hit 2 same level
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 2,  0,3,1,1)); // hit 3 + done
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 2,  0,3,0,0));
    vt.push_back(row(0,0,0,0,1,0,0, 5, 0, 5,  0,3,0,0)); // EQ5,EQ5
    vt.push_back(row(0,0,0,0,1,1,0, 5, 0, 5,  0,3,0,0));
    vt.push_back(row(0,1,0,2,0,0,0, 0, 0, 5,  1,0,0,0)); // already true
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,1,1,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  0,1,1,1));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  0,1,0,0));
    vt.push_back(row(0,1,0,0,0,0,0, 0, 0, 0,  0,1,0,1)); // n=0
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 0,  0,1,0,0));
    vt.push_back(row(0,1,0,2,0,0,0, 0, 0, 0,  1,0,0,0)); // abort test
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,1,1,0));
    vt.push_back(row(0,0,1,0,0,0,0, 0, 0, 5,  0,0,0,0)); // abort wins
    vt.push_back(row(0,1,0,2,0,0,0, 0, 0, 5,  1,0,0,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,1,1,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  0,1,1,1));
    vt.push_back(row(0,1,0,3,0,0,0, 0, 0, 5,  1,0,0,0)); // write while busy
    vt.push_back(row(0,0,0,0,1,2,0, 5, 0, 5,  1,1,1,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,2,1,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,2,0,0)); // entry 2 still EQ 0
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 0,  0,2,1,1));
    vt.push_back(row(0,0,0,0,1,2,0, 7, 0, 0,  0,2,0,0)); // idle write EQ 7
    vt.push_back(row(0,1,0,3,0,0,0, 0, 0, 5,  1,0,0,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,1,1,0));
    vt.push_back(row(0,1,0,0,0,0,0, 0, 0, 5,  1,2,1,0)); // start while busy
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,2,0,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 7,  0,2,1,1));
    vt.push_back(row(0,0,1,0,0,0,0, 0, 0, 0,  0,2,0,0)); // abort idle
    vt.push_back(row(0,1,1,1,0,0,0, 0, 0, 0,  1,0,0,0)); // start+abort
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  0,0,1,1));
    vt.push_back(row(0,1,0,7,0,0,0, 0, 0, 0,  1,0,0,0)); // n=7 clamps to 4
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,1,1,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,2,1,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 7,  1,3,1,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 2,  0,3,1,1));
    vt.push_back(row(0,1,0,2,0,0,0, 0, 0, 0,  1,0,0,0)); // reset mid-run
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 5,  1,1,1,0));
    vt.push_back(row(1,0,0,0,0,0,0, 0, 0, 5,  0,0,0,0));
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 0,  0,0,0,0));
    vt.push_back(row(0,1,0,1,0,0,0, 0, 0, 0,  1,0,0,0)); // table reset to EQ 0
    vt.push_back(row(0,0,0,0,0,0,0, 0, 0, 0,  0,0,1,1));

    foreach (vt[i]) begin
      set_in(vt[i].r, vt[i].s, vt[i].a, vt[i].n, vt[i].we, vt[i].idx,
             vt[i].op, vt[i].lo, vt[i].hi, vt[i].v);
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {vt[i].busy, 2'(vt[i].st), vt[i].hit, vt[i].dn, 1'b0});
    end

    // Long wait: EQ 3 against a value stuck at 0.
    set_in(0, 0, 0, 0, 1, 0, 0, 3, 0, 0);
    tick_model("cfg_eq3");
    set_in(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick_model("start_eq3");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef VALUE_COND_WAITER_TIMEOUT_EN
    begin
      int k;
      bit seen;
      seen = 0;
      for (k = 1; k <= 4 * TO; k++) begin
        tick_model("to_wait");
        if (done) chk("to_no_done", 6'(done), 6'd0);
        if (timeout) begin seen = 1; break; end
      end
      chk("to_seen", 6'(seen), 6'd1);
      chk("to_cycle", 6'(k), 6'(TO));
      tick_model("to_after");
      chk("to_idle", 6'(busy), 6'd0);
    end
`else
    for (int k = 0; k < 100; k++) begin
      tick_model("hold_busy");
      chk("hold_busy_raw", {busy, stage, stage_hit, done, timeout}, 6'b100000);
    end
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick_model("abort_hold");
`endif

    // Randomized traffic against the model.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick_model("rand_rst");
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] v;
      v = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
      set_in($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 7),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 7),
             W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), v);
      tick_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/value_cond_waiter.md
# value_cond_waiter

Synthesizable sequenced-condition monitor that consumes a design `value` stream. It steps through a programmed list of level-sensitive conditions (equal, less-than, greater-than, not-equal, open range) and waits for each in order. It reports per-stage hits and a final done pulse. It is the hardware counterpart of the `wait(value ...)` chains used in the dynamic-scheduler tests, and sits directly downstream of whatever drives `value`.

## Interface
- `WIDTH`, 32, width of `value` and bounds (unsigned compare).
- `NUM_STAGES`, 4, depth of condition table.
- `TIMEOUT_CYCLES`, 1024, per-stage timeout limit (used only with the timeout feature).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `value` in WIDTH: monitored value, sampled each rising edge.
- `cfg_we` in 1: write condition table entry.
- `cfg_idx` in $clog2(NUM_STAGES): entry index.
- `cfg_op` in 3: 0=EQ (v==lo), 1=LT (v<lo), 2=GT (v>lo), 3=NE (v!=lo), 4=RANGE (lo<v<hi); 5-7 never match.
- `cfg_lo`, `cfg_hi` in WIDTH: bounds.
- `n_stages` in $clog2(NUM_STAGES+1): stages to run; sampled on accepted `start`.
- `start` in 1: begin sequence.
- `abort` in 1: cancel sequence.
- `busy` out 1: sequence in progress.
- `stage` out $clog2(NUM_STAGES): current stage index.
- `stage_hit` out 1: one-cycle pulse; a stage's condition matched.
- `done` out 1: one-cycle pulse; all stages matched.
- `timeout` out 1: one-cycle pulse (timeout build only; tied 0 otherwise).

## Operation
- FSM states: IDLE, WAIT.
- IDLE + `start`:
  - if `n_stages`==0, pulse `done` next cycle and stay IDLE;
  - else go to WAIT with `stage`=0 and latch `n_stages` (values >NUM_STAGES clamp to NUM_STAGES).
- WAIT: each edge, evaluate entry[`stage`] against `value` combinationally.
  - On match: pulse `stage_hit`.
  - If `stage`==last, pulse `done`, return to IDLE, and hold `stage` at last.
  - Otherwise increment `stage`.
- Level-sensitive: a condition already true on entry to a stage matches at the first WAIT edge. It does not wait for a change.
- At most one stage advances per cycle, even if consecutive conditions are all true.
- `start` while busy is ignored.
- `cfg_we` while busy is ignored (table frozen during a sequence). In IDLE, writes take effect next cycle.
- `abort` in WAIT: return to IDLE and set `stage`=0. No `stage_hit`/`done` that cycle, even if the condition matches (abort wins). `abort` in IDLE is a no-op.
- `start` and `abort` in the same IDLE cycle: `start` is accepted.
- RANGE with `hi`<=`lo`+1 never matches.

## Timing
- Reset values:
  - `busy`=0, `stage`=0, `stage_hit`=0, `done`=0, `timeout`=0, FSM=IDLE.
  - Every table entry set to op=EQ, lo=0, hi=0.
- `start` at edge N → `busy`=1 after N. First evaluation at edge N+1.
- Condition true at edge M → `stage_hit` (and `done` if last) high for the cycle after M. `busy` falls after M on the last stage.
- Minimum sequence of k stages: `start` plus k cycles.
- `rst` mid-sequence returns to reset state on that edge. No pulses are emitted.

## Configuration
- `VALUE_COND_WAITER_TIMEOUT_EN` defined:
  - per-stage counter cleared on stage entry, incremented each WAIT cycle without match.
  - Reaching `TIMEOUT_CYCLES` pulses `timeout`, returns to IDLE, emits no `done`.
  - Match on the expiry cycle: match wins.
  - `abort` on the expiry cycle: abort wins, no `timeout`.
- Undefined: no counter is built, `timeout` is tied 0, and WAIT persists indefinitely.

## Test plan
- Table {EQ 2, LT 2, EQ 0, RANGE lo=1 hi=3}, `n_stages`=4; `value` 0,1 (hold 2 cyc each), 2,0,2 → `stage_hit` after each of 2, 0, 0(same-level stage 2, next cycle), 2; `done` once; total four hits.
- Table {EQ 5, EQ 5}, `value` held 5 before `start` → hits on edges N+1 and N+2; `done` with second hit.
- `n_stages`=0 → `done` one cycle after `start`; `busy` never asserted.
- Abort in stage 1 on the same edge the condition matches → no `stage_hit`; `busy`=0, `stage`=0 next cycle; a subsequent `start` runs cleanly.
- `cfg_we` while busy altering entry 2 → ignored; sequence uses the original entry; write in IDLE is visible.
- Timeout build, `TIMEOUT_CYCLES`=8, `value` stuck at 0 against EQ 3 → `timeout` pulse at cycle 8 of stage, no `done`. Non-timeout build: `busy` stays 1 for 100 cycles.
